// File: rtl/irrigation_zone_controller.sv
// Multi-zone irrigation controller.
// Synchronises and debounces tank-level, soil and climate sensors. Flags an
// inconsistent tank level and raises the alarm. Drives the tank inlet valve with
// hysteresis, waters the zones round-robin with timed sprinkler/drip runs, and
// scans a 4-digit active-low 7-segment display.
// Optional feature: define RAIN_LOCKOUT_EN to add the `chuva` rain input. A
// debounced rain signal blocks and aborts runs like the alarm does, and shows
// 'C' on digit2 of the irrigation page.
// Ports:
//   clock, reset             rising-edge clock, async active-high reset
//   high, middle, low        tank probes (1 = water present)
//   umidadeDoSolo            per-zone soil moisture (1 = wet)
//   umidadeDoAr, temperatura 1 = humid air, 1 = hot
//   seletor                  display page: 0 = tank, 1 = irrigation
//   chuva                    rain sensor (RAIN_LOCKOUT_EN only)
//   erro, saidaDoAlarme      level inconsistency, low-water/erro alarm
//   ValvulaDeEntrada         tank inlet valve
//   ValvulaDeAspersao        sprinkler valves, one-hot or zero
//   ValvulaDeGotejamento     drip valves, one-hot or zero
//   segments, digits         {g,f,e,d,c,b,a} and digit enables, both active-low
module irrigation_zone_controller #(
  parameter int unsigned NUM_ZONES       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SPRINK_CYCLES   = 100,
  parameter int unsigned DRIP_CYCLES     = 200,
  parameter int unsigned COOLDOWN_CYCLES = 10,
  parameter int unsigned SCAN_DIV        = 1000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 high,
  input  logic                 middle,
  input  logic                 low,
  input  logic [NUM_ZONES-1:0] umidadeDoSolo,
  input  logic                 umidadeDoAr,
  input  logic                 temperatura,
  input  logic                 seletor,
`ifdef RAIN_LOCKOUT_EN
  input  logic                 chuva,
`endif
  output logic                 erro,
  output logic                 saidaDoAlarme,
  output logic                 ValvulaDeEntrada,
  output logic [NUM_ZONES-1:0] ValvulaDeAspersao,
  output logic [NUM_ZONES-1:0] ValvulaDeGotejamento,
  output logic [6:0]           segments,
  output logic [3:0]           digits
);

  // Sensor vector layout: 0 high, 1 middle, 2 low, 3 air, 4 temp, 5 rain, 6.. soil
  localparam int unsigned NI      = NUM_ZONES + 6;
  localparam int unsigned DCW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RUN_MAX = (SPRINK_CYCLES > DRIP_CYCLES) ? SPRINK_CYCLES : DRIP_CYCLES;
  localparam int unsigned CNT_MAX = (RUN_MAX > COOLDOWN_CYCLES) ? RUN_MAX : COOLDOWN_CYCLES;
  localparam int unsigned RCW     = $clog2(CNT_MAX + 1);
  localparam int unsigned ZW      = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
  localparam int unsigned ZW1     = ZW + 1;
  localparam int unsigned SCW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_G     = 7'h42;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
`ifdef RAIN_LOCKOUT_EN
  localparam logic [6:0] SEG_C     = 7'h46;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_WATER, S_COOL} state_t;

  logic           chuva_raw;
  logic [NI-1:0]  raw, sync1, sync2, deb;
  logic [DCW-1:0] dcnt [NI];

`ifdef RAIN_LOCKOUT_EN
  assign chuva_raw = chuva;
`else
  assign chuva_raw = 1'b0;
`endif
  assign raw = {umidadeDoSolo, chuva_raw, temperatura, umidadeDoAr, low, middle, high};

  logic                 d_high, d_mid, d_low, d_ar, d_temp, d_chuva;
  logic [NUM_ZONES-1:0] d_soil, dry;
  logic                 erro_c, alarm_c, block_c;
  logic [1:0]           lvl;

  assign d_high  = deb[0];
  assign d_mid   = deb[1];
  assign d_low   = deb[2];
  assign d_ar    = deb[3];
  assign d_temp  = deb[4];
  assign d_chuva = deb[5];
  assign d_soil  = deb[NI-1:6];
  assign dry     = ~d_soil;
  assign erro_c  = (d_high & ~d_mid) | (d_mid & ~d_low);
  assign alarm_c = ~d_low | erro_c;
  assign block_c = alarm_c | d_chuva;
  assign lvl     = 2'(d_high) + 2'(d_mid) + 2'(d_low);

  state_t               state, state_n;
  logic [ZW-1:0]        zone, zone_n, ptr, ptr_n, pick;
  logic [ZW1-1:0]       cand;
  logic                 found, mode, mode_n;
  logic [RCW-1:0]       rcnt, rcnt_n;
  logic [NUM_ZONES-1:0] zone_oh, asp_n, got_n;
  logic                 inlet_n;
  logic [SCW-1:0]       scan, scan_n;
  logic [1:0]           idx, idx_n;
  logic [6:0]           seg_n;

  assign zone_oh = NUM_ZONES'(1) << zone;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // First dry zone at or after the pointer, wrapping round
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_ZONES; i++) begin
      cand = ZW1'(ptr) + ZW1'(i);
      if (cand >= ZW1'(NUM_ZONES)) cand = cand - ZW1'(NUM_ZONES);
      if (!found && dry[cand[ZW-1:0]]) begin
        found = 1'b1;
        pick  = cand[ZW-1:0];
      end
    end
  end

  // Scheduler next state and next valve values; valves drop on the exit cycle
  always_comb begin
    state_n = state;
    zone_n  = zone;
    mode_n  = mode;
    ptr_n   = ptr;
    rcnt_n  = rcnt;
    asp_n   = '0;
    got_n   = '0;
    case (state)
      S_IDLE: if (!block_c && (|dry)) state_n = S_SELECT;
      S_SELECT: begin
        if (block_c || !found) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_WATER;
          zone_n  = pick;
          mode_n  = d_mid & (d_temp | ~d_ar);
          rcnt_n  = mode_n ? RCW'(SPRINK_CYCLES - 1) : RCW'(DRIP_CYCLES - 1);
          if (mode_n) asp_n = NUM_ZONES'(1) << pick;
          else        got_n = NUM_ZONES'(1) << pick;
        end
      end
      S_WATER: begin
        if (block_c || d_soil[zone] || rcnt == '0) begin
          state_n = S_COOL;
          rcnt_n  = RCW'(COOLDOWN_CYCLES - 1);
          ptr_n   = (zone == ZW'(NUM_ZONES - 1)) ? '0 : zone + ZW'(1);
        end else begin
          rcnt_n = rcnt - RCW'(1);
          if (mode) asp_n = zone_oh;
          else      got_n = zone_oh;
        end
      end
      S_COOL: begin
        if (rcnt == '0) state_n = S_IDLE;
        else            rcnt_n  = rcnt - RCW'(1);
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Inlet hysteresis: open below middle, close at high or on a bad reading
  always_comb begin
    inlet_n = ValvulaDeEntrada;
    if (~d_mid & ~erro_c)      inlet_n = 1'b1;
    else if (d_high | erro_c)  inlet_n = 1'b0;
  end

  // Display scan and segment content for the digit about to be enabled
  always_comb begin
    scan_n = scan + SCW'(1);
    idx_n  = idx;
    if (scan == SCW'(SCAN_DIV - 1)) begin
      scan_n = '0;
      idx_n  = idx + 2'd1;
    end
    seg_n = SEG_BLANK;
    if (!seletor) begin
      if (idx_n == 2'd0) seg_n = erro_c ? SEG_E : seg7({2'b00, lvl});
      if (idx_n == 2'd3 && alarm_c) seg_n = SEG_A;
    end else begin
      if (idx_n == 2'd0) seg_n = (state == S_WATER) ? (mode ? SEG_A : SEG_G) : SEG_DASH;
      if (idx_n == 2'd1 && state == S_WATER) seg_n = seg7(4'(zone) + 4'd1);
`ifdef RAIN_LOCKOUT_EN
      if (idx_n == 2'd2 && d_chuva) seg_n = SEG_C;
`endif
    end
  end

  // All state and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1                <= '0;
      sync2                <= '0;
      deb                  <= '0;
      for (int i = 0; i < NI; i++) dcnt[i] <= '0;
      state                <= S_IDLE;
      zone                 <= '0;
      ptr                  <= '0;
      mode                 <= 1'b0;
      rcnt                 <= '0;
      scan                 <= '0;
      idx                  <= 2'd0;
      erro                 <= 1'b0;
      saidaDoAlarme        <= 1'b0;
      ValvulaDeEntrada     <= 1'b0;
      ValvulaDeAspersao    <= '0;
      ValvulaDeGotejamento <= '0;
      segments             <= SEG_BLANK;
      digits               <= 4'b1110;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NI; i++) begin
        if (sync2[i] != deb[i]) begin
          if (dcnt[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i]  <= sync2[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + DCW'(1);
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
      state                <= state_n;
      zone                 <= zone_n;
      ptr                  <= ptr_n;
      mode                 <= mode_n;
      rcnt                 <= rcnt_n;
      scan                 <= scan_n;
      idx                  <= idx_n;
      erro                 <= erro_c;
      saidaDoAlarme        <= alarm_c;
      ValvulaDeEntrada     <= inlet_n;
      ValvulaDeAspersao    <= asp_n;
      ValvulaDeGotejamento <= got_n;
      segments             <= seg_n;
      digits               <= ~(4'b0001 << idx_n);
    end
  end

endmodule
